// File: rtl/pipe_rx_lane_deskew_if.sv
// PIPE RX lane bundle into the deskew buffer and the aligned bundle out of it.
// master drives the raw lanes and link control; slave is the deskew block.
interface pipe_rx_lane_deskew_if #(
    parameter int LANESNUMBER = 16,
    parameter int PIPEWIDTH   = 8,
    parameter int SKEWW       = 4
);
    logic                                  gen3_mode;
    logic [LANESNUMBER-1:0]                active_lanes;
    logic                                  realign;
    logic [PIPEWIDTH*LANESNUMBER-1:0]      RxData;
    logic [(PIPEWIDTH/8)*LANESNUMBER-1:0]  RxDataK;
    logic [LANESNUMBER-1:0]                RxDataValid;
    logic [LANESNUMBER-1:0]                RxValid;
    logic [LANESNUMBER-1:0]                RxStartBlock;
    logic [2*LANESNUMBER-1:0]              RxSyncHeader;
    logic [PIPEWIDTH*LANESNUMBER-1:0]      DeskewData;
    logic [(PIPEWIDTH/8)*LANESNUMBER-1:0]  DeskewDataK;
    logic [LANESNUMBER-1:0]                DeskewStartBlock;
    logic [2*LANESNUMBER-1:0]              DeskewSyncHeader;
    logic                                  DeskewValid;
    logic                                  deskew_aligned;
    logic                                  deskew_error;
    logic [SKEWW-1:0]                      skew_cycles;

    modport master (
        output gen3_mode, active_lanes, realign, RxData, RxDataK, RxDataValid,
               RxValid, RxStartBlock, RxSyncHeader,
        input  DeskewData, DeskewDataK, DeskewStartBlock, DeskewSyncHeader,
               DeskewValid, deskew_aligned, deskew_error, skew_cycles
    );

    modport slave (
        input  gen3_mode, active_lanes, realign, RxData, RxDataK, RxDataValid,
               RxValid, RxStartBlock, RxSyncHeader,
        output DeskewData, DeskewDataK, DeskewStartBlock, DeskewSyncHeader,
               DeskewValid, deskew_aligned, deskew_error, skew_cycles
    );
endinterface

// File: rtl/pipe_rx_lane_deskew.sv
// Multi-lane RX deskew: per-lane FIFOs are trimmed to a common alignment marker
// (COM or ordered-set block start), then popped in lockstep.
module pipe_rx_lane_deskew #(
    parameter int LANESNUMBER = 16,
    parameter int PIPEWIDTH   = 8,
    parameter int DEPTH       = 8,
    parameter int SKEWW       = $clog2(DEPTH) + 1
) (
    input logic                  CLK,
    input logic                  reset,
    pipe_rx_lane_deskew_if.slave dsk_io
);
    localparam int KW = PIPEWIDTH / 8;
    localparam int EW = PIPEWIDTH + KW + 3;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {FLUSH, SEARCH, ALIGNED} state_t;
    state_t state_q, state_d;

    // entry layout: {data, K, StartBlock, SyncHeader}
    logic [EW-1:0]              mem_q [LANESNUMBER][DEPTH];
    logic [PW-1:0]              wr_ptr_q [LANESNUMBER];
    logic [PW-1:0]              rd_ptr_q [LANESNUMBER];
    logic [EW-1:0]              head [LANESNUMBER];
    logic [LANESNUMBER-1:0]     act, act_q, wr_req, we, pop, empty, full, mk;
    logic [SKEWW-1:0]           cnt_q, cnt_d, skew_q, skew_d;
    logic [PIPEWIDTH*LANESNUMBER-1:0] data_q, data_d;
    logic [KW*LANESNUMBER-1:0]  k_q, k_d;
    logic [LANESNUMBER-1:0]     sb_q, sb_d;
    logic [2*LANESNUMBER-1:0]   sh_q, sh_d;
    logic valid_q, valid_d, err_q, err_d;
    logic emit, mismatch, overflow, force_flush, lanes_on, all_hold, all_ne, any_mk, all_mk;

    assign act         = dsk_io.active_lanes;
    assign wr_req      = act & dsk_io.RxValid & dsk_io.RxDataValid;
    assign force_flush = dsk_io.realign | (act != act_q);
    assign lanes_on    = |act;

    always_comb begin
        for (int i = 0; i < LANESNUMBER; i++) begin
            head[i]  = mem_q[i][rd_ptr_q[i][AW-1:0]];
            empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
            full[i]  = ((wr_ptr_q[i] - rd_ptr_q[i]) == PW'(DEPTH));
            mk[i]    = !empty[i] && (dsk_io.gen3_mode ? (head[i][2] && head[i][1:0] == 2'b01)
                                                      : (head[i][3+KW +: 8] == 8'hBC && head[i][3]));
        end
    end

    assign all_hold = lanes_on && (&(mk | ~act));
    assign all_ne   = lanes_on && (&(~empty | ~act));
    assign any_mk   = |(mk & act);
    assign all_mk   = &(mk | ~act);

    always_comb begin
        state_d  = state_q;
        pop      = '0;
        emit     = 1'b0;
        mismatch = 1'b0;
        cnt_d    = cnt_q;
        skew_d   = skew_q;
        case (state_q)
            FLUSH: begin
                cnt_d   = '0;
                state_d = SEARCH;
            end
            SEARCH: begin
                pop = act & ~empty & ~mk;
                if (all_hold) begin
                    pop     = act;
                    emit    = 1'b1;
                    skew_d  = cnt_q;
                    cnt_d   = '0;
                    state_d = ALIGNED;
                end else if (|(act & mk)) begin
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + SKEWW'(1);
                end
            end
            ALIGNED: begin
                if (all_ne) begin
                    pop = act;
                    if (any_mk && !all_mk) begin
                        mismatch = 1'b1;
                    end else begin
                        emit = 1'b1;
                    end
                end
            end
            default: state_d = FLUSH;
        endcase

        // a pop in the same cycle frees the slot, so that write is not an overflow
        overflow = (state_q != FLUSH) && (|(wr_req & full & ~pop));
        we       = (state_q != FLUSH) ? (wr_req & ~(full & ~pop)) : '0;
        err_d    = overflow | mismatch;
        if (err_d || force_flush) begin
            state_d = FLUSH;
            emit    = 1'b0;
            skew_d  = skew_q;
        end

        valid_d = emit;
        data_d  = '0;
        k_d     = '0;
        sb_d    = '0;
        sh_d    = '0;
        for (int i = 0; i < LANESNUMBER; i++) begin
            if (emit && act[i]) begin
                data_d[i*PIPEWIDTH +: PIPEWIDTH] = head[i][3+KW +: PIPEWIDTH];
                k_d[i*KW +: KW]                  = head[i][3 +: KW];
                sb_d[i]                          = head[i][2];
                sh_d[2*i +: 2]                   = head[i][1:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < LANESNUMBER; i++) begin
            if (we[i]) begin
                mem_q[i][wr_ptr_q[i][AW-1:0]] <= {dsk_io.RxData[i*PIPEWIDTH +: PIPEWIDTH],
                                                  dsk_io.RxDataK[i*KW +: KW],
                                                  dsk_io.RxStartBlock[i],
                                                  dsk_io.RxSyncHeader[2*i +: 2]};
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LANESNUMBER; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
        end else if (state_q == FLUSH) begin
            for (int i = 0; i < LANESNUMBER; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANESNUMBER; i++) begin
                if (we[i])  wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
                if (pop[i]) rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= FLUSH;
            act_q   <= '0;
            cnt_q   <= '0;
            skew_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            k_q     <= '0;
            sb_q    <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            act_q   <= act;
            cnt_q   <= cnt_d;
            skew_q  <= skew_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            data_q  <= data_d;
            k_q     <= k_d;
            sb_q    <= sb_d;
            sh_q    <= sh_d;
        end
    end

    assign dsk_io.DeskewData       = data_q;
    assign dsk_io.DeskewDataK      = k_q;
    assign dsk_io.DeskewStartBlock = sb_q;
    assign dsk_io.DeskewSyncHeader = sh_q;
    assign dsk_io.DeskewValid      = valid_q;
    assign dsk_io.deskew_error     = err_q;
    assign dsk_io.deskew_aligned   = (state_q == ALIGNED);
    assign dsk_io.skew_cycles      = skew_q;
endmodule

// File: tb/tb_pipe_rx_lane_deskew.sv
// Directed bench for pipe_rx_lane_deskew at 4 lanes x 8 bits, DEPTH 8.
module tb_pipe_rx_lane_deskew;
    logic CLK;
    logic reset;
    int   n_pass = 0;
    int   n_tot  = 0;
    logic [3:0] mask;
    bit   g3;

    pipe_rx_lane_deskew_if #(.LANESNUMBER(4), .PIPEWIDTH(8), .SKEWW(4)) dif ();
    pipe_rx_lane_deskew #(.LANESNUMBER(4), .PIPEWIDTH(8), .DEPTH(8), .SKEWW(4)) dut (
        .CLK(CLK), .reset(reset), .dsk_io(dif)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       k;
        logic       sb;
        logic [1:0] sh;
    } item_t;

    typedef struct {
        logic       dv;
        logic [7:0] d;
        logic       k;
        logic       ev;
        logic [7:0] ed;
        logic       ek;
        logic       eal;
    } vec_t;

    vec_t tbl [6];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
        n_tot++;
        if (act_v !== exp_v) $display("FAIL %s: got %0h expected %0h at %0t", nm, act_v, exp_v, $time);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic item_t item(input int idx, input bit gen3);
        item_t it;
        if (idx == 0) it = gen3 ? '{d: 8'hE1, k: 1'b0, sb: 1'b1, sh: 2'b01}
                                : '{d: 8'hBC, k: 1'b1, sb: 1'b0, sh: 2'b00};
        else          it = gen3 ? '{d: 8'(8'h10 + idx), k: 1'b0, sb: 1'b0, sh: 2'b10}
                                : '{d: 8'(8'h10 + idx), k: 1'b0, sb: 1'b0, sh: 2'b00};
        return it;
    endfunction

    task automatic set_lane(input int i, input logic dv, input item_t it);
        dif.RxDataValid[i]      = dv;
        dif.RxData[i*8 +: 8]    = dv ? it.d : 8'h00;
        dif.RxDataK[i]          = dv ? it.k : 1'b0;
        dif.RxStartBlock[i]     = dv ? it.sb : 1'b0;
        dif.RxSyncHeader[2*i +: 2] = dv ? it.sh : 2'b00;
    endtask

    task automatic idle(input int n);
        item_t z;
        z = '0;
        for (int i = 0; i < 4; i++) set_lane(i, 1'b0, z);
        for (int c = 0; c < n; c++) tick();
    endtask

    task automatic resync();
        idle(0);
        dif.realign = 1'b1;
        tick();
        dif.realign = 1'b0;
        idle(2);
    endtask

    // lane i carries item(t - dly[i]) for nitems cycles; each emitted word is
    // checked against the next expected item on active lanes and zero elsewhere
    task automatic run_stream(input int d0, input int d1, input int d2, input int d3,
                              input int nitems, input int niter,
                              output int first_v, output int n_v, output int n_err, output int n_al);
        int    dly [4];
        int    idx;
        item_t it;
        logic [47:0] exp_bus;
        logic [31:0] ed;
        logic [3:0]  ek, esb;
        logic [7:0]  esh;
        dly = '{d0, d1, d2, d3};
        first_v = -1; n_v = 0; n_err = 0; n_al = 0;
        for (int t = 0; t < niter; t++) begin
            for (int i = 0; i < 4; i++) begin
                idx = t - dly[i];
                it  = item(idx < 0 ? 0 : idx, g3);
                set_lane(i, (idx >= 0 && idx < nitems), it);
            end
            tick();
            if (dif.deskew_error) n_err++;
            if (dif.deskew_aligned) n_al++;
            if (dif.DeskewValid) begin
                if (first_v < 0) first_v = t;
                it = item(n_v, g3);
                ed = '0; ek = '0; esb = '0; esh = '0;
                for (int i = 0; i < 4; i++) begin
                    if (mask[i]) begin
                        ed[i*8 +: 8]   = it.d;
                        ek[i]          = it.k;
                        esb[i]         = it.sb;
                        esh[2*i +: 2]  = it.sh;
                    end
                end
                exp_bus = {ed, ek, esb, esh};
                chk($sformatf("stream_word%0d", n_v),
                    {16'h0, dif.DeskewData, dif.DeskewDataK, dif.DeskewStartBlock, dif.DeskewSyncHeader},
                    {16'h0, exp_bus});
                n_v++;
            end
        end
        idle(0);
    endtask

    initial begin
        int fv, nv, ne, na;
        item_t it;
        int errs;

        tbl[0] = '{1'b1, 8'hBC, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'h01, 1'b0, 1'b1, 8'hBC, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};

        reset = 1'b0;
        g3 = 1'b0;
        mask = 4'b1111;
        dif.gen3_mode = 1'b0;
        dif.active_lanes = mask;
        dif.realign = 1'b0;
        dif.RxValid = 4'b1111;
        dif.RxData = '0; dif.RxDataK = '0; dif.RxDataValid = '0;
        dif.RxStartBlock = '0; dif.RxSyncHeader = '0;
        idle(3);
        chk("rst_valid",   64'(dif.DeskewValid), 64'd0);
        chk("rst_aligned", 64'(dif.deskew_aligned), 64'd0);
        chk("rst_error",   64'(dif.deskew_error), 64'd0);
        chk("rst_skew",    64'(dif.skew_cycles), 64'd0);
        chk("rst_data",    64'({dif.DeskewData, dif.DeskewDataK, dif.DeskewStartBlock, dif.DeskewSyncHeader}), 64'd0);
        reset = 1'b1;
        idle(4);

        // all lanes COM together, then a short incrementing stream
        for (int r = 0; r < 6; r++) begin
            it = '{d: tbl[r].d, k: tbl[r].k, sb: 1'b0, sh: 2'b00};
            for (int i = 0; i < 4; i++) set_lane(i, tbl[r].dv, it);
            tick();
            chk($sformatf("tbl%0d_valid", r), 64'(dif.DeskewValid), 64'(tbl[r].ev));
            chk($sformatf("tbl%0d_data", r), 64'(dif.DeskewData), 64'({4{tbl[r].ed}}));
            chk($sformatf("tbl%0d_k", r), 64'(dif.DeskewDataK), 64'({4{tbl[r].ek}}));
            chk($sformatf("tbl%0d_aligned", r), 64'(dif.deskew_aligned), 64'(tbl[r].eal));
            chk($sformatf("tbl%0d_error", r), 64'(dif.deskew_error), 64'd0);
        end
        chk("aligned_skew0", 64'(dif.skew_cycles), 64'd0);

        // lone marker on lane 1 while aligned
        it = '{d: 8'h20, k: 1'b0, sb: 1'b0, sh: 2'b00};
        for (int i = 0; i < 4; i++) set_lane(i, 1'b1, (i == 1) ? item(0, 1'b0) : it);
        tick();
        chk("lone_mk_pre_err", 64'(dif.deskew_error), 64'd0);
        idle(1);
        chk("lone_mk_err", 64'(dif.deskew_error), 64'd1);
        chk("lone_mk_aligned", 64'(dif.deskew_aligned), 64'd0);
        chk("lone_mk_valid", 64'(dif.DeskewValid), 64'd0);
        idle(1);
        chk("lone_mk_err_pulse", 64'(dif.deskew_error), 64'd0);
        run_stream(0, 0, 0, 0, 5, 8, fv, nv, ne, na);
        chk("realign_first", 64'(fv), 64'd1);
        chk("realign_count", 64'(nv), 64'd5);
        chk("realign_err", 64'(ne), 64'd0);
        chk("realign_aligned", 64'(dif.deskew_aligned), 64'd1);

        // lanes 0..3 skewed by 0,1,2,3 cycles
        resync();
        run_stream(0, 1, 2, 3, 9, 15, fv, nv, ne, na);
        chk("skew3_first", 64'(fv), 64'd4);
        chk("skew3_count", 64'(nv), 64'd9);
        chk("skew3_err", 64'(ne), 64'd0);
        chk("skew3_skew", 64'(dif.skew_cycles), 64'd3);

        // lane 2 eight cycles late overflows the other lanes
        resync();
        run_stream(0, 0, 8, 0, 9, 18, fv, nv, ne, na);
        chk("ovf_err_pulses", 64'(ne), 64'd1);
        chk("ovf_valid", 64'(nv), 64'd0);
        chk("ovf_aligned", 64'(na), 64'd0);
        chk("ovf_skew_hold", 64'(dif.skew_cycles), 64'd3);

        // width change 1111 -> 0011 in mid-stream
        resync();
        errs = 0;
        for (int t = 0; t < 10; t++) begin
            if (t == 5) begin
                mask = 4'b0011;
                dif.active_lanes = mask;
            end
            for (int i = 0; i < 4; i++) set_lane(i, 1'b1, item(t, 1'b0));
            tick();
            if (dif.deskew_error) errs++;
            chk($sformatf("width_valid%0d", t), 64'(dif.DeskewValid), 64'((t >= 1 && t <= 4) ? 1 : 0));
            if (t == 4) chk("width_aligned_before", 64'(dif.deskew_aligned), 64'd1);
            if (t == 5) chk("width_aligned_after", 64'(dif.deskew_aligned), 64'd0);
        end
        idle(0);
        chk("width_no_err", 64'(errs), 64'd0);

        // gen3 block markers on two lanes, lane 1 two cycles late
        g3 = 1'b1;
        dif.gen3_mode = 1'b1;
        resync();
        run_stream(0, 2, 0, 0, 9, 14, fv, nv, ne, na);
        chk("gen3_first", 64'(fv), 64'd3);
        chk("gen3_count", 64'(nv), 64'd9);
        chk("gen3_err", 64'(ne), 64'd0);
        chk("gen3_skew", 64'(dif.skew_cycles), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
